nic_interface: RTL and testbench
================================

Name: nic_interface

Overview:
- Network interface controller; the responder at the NIC end of the processor's memory-mapped NIC port.
- Services the pipeline's NIC loads and stores (nicEn / nicEnWr / 2-bit address) using one-entry input and output channel buffers.
- Bridges those buffers to the ring router with send/ready handshakes.
- Read data returns registered, one cycle after the request, which matches the pipeline's stage-3 capture of NIC data.

Parameters:
DATA_WIDTH, 64, width of processor and network data words
ADDR_WIDTH, 2, processor-side register address width

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
nicEn  input  1  processor NIC access enable
nicEnWr  input  1  1 = write (store), 0 = read (load); valid when nicEn=1
addr_nic  input  ADDR_WIDTH  register select
d_in  input  DATA_WIDTH  processor store data
d_out  output  DATA_WIDTH  processor load data, registered
net_si  input  1  router has a packet for the NIC
net_ri  output  1  NIC can accept an input packet
net_di  input  DATA_WIDTH  input packet from router
net_so  output  1  NIC has a packet for the router
net_ro  input  1  router can accept the NIC's packet
net_do  output  DATA_WIDTH  output packet to router

Behaviour:
- Reset (async, rst=1): in_buf=0, in_full=0, out_buf=0, out_full=0, d_out=0. This gives net_so=0, net_ri=1 and net_do=0. Reset mid-transfer discards buffered data.
- Address map:
  - 00: input channel buffer (read).
  - 01: input status (read; bit0 = in_full, upper bits 0).
  - 10: output channel buffer (write).
  - 11: output status (read; bit0 = out_full, upper bits 0).
- Processor read (nicEn=1, nicEnWr=0) at posedge:
  - d_out <= selected value; valid the following cycle (1-cycle latency).
  - d_out holds its value when there is no read.
  - Reading addr 10 returns 0.
  - Status reads return the flag value sampled before any same-edge update.
- Reading addr 00:
  - When in_full=1: d_out <= in_buf and in_full <= 0 on the same edge.
  - When in_full=0: returns stale in_buf; flags unchanged.
- Processor write (nicEn=1, nicEnWr=1):
  - Addr 10 with out_full=0: out_buf <= d_in, out_full <= 1.
  - Addr 10 with out_full=1: dropped, no state change.
  - Writes to 00, 01 and 11 are ignored.
  - d_out is unchanged by any write.
- nicEn=0: nicEnWr, addr_nic and d_in are don't-care.
- Input side:
  - net_ri = ~in_full (combinational from the flag register).
  - net_si=1 and net_ri=1 at posedge: in_buf <= net_di, in_full <= 1.
  - net_si while full: no capture; the router must hold its packet.
- Output side:
  - net_so = out_full; net_do = out_buf.
  - net_so=1 and net_ro=1 at posedge: out_full <= 0; out_buf is retained.
- Simultaneous events:
  - Read of 00 and net_si in the same cycle with in_full=1: the read clears the flag, no capture (net_ri was 0). The next input is accepted one cycle later at the earliest.
  - Write of 10 and an output handshake in the same cycle: the write is dropped (out_full=1 at the edge). Software must poll addr 11 first.
  - Read and input capture with in_full=0: capture proceeds; d_out gets the stale in_buf.
- Throughput: at most one packet per 2 cycles per direction (single-entry buffers, flag-gated).
- No combinational path from any processor-side input to d_out, or from net_ro to net_so.

Test Plan:
- Reset: assert rst mid-cycle with in_full=1 and out_full=1 -> immediately net_so=0, net_ri=1, d_out=0; after release, read of 01 returns 0 the next cycle.
- Input path: net_si=1, net_di=64'hDEAD_BEEF_0000_0001 for one cycle -> net_ri drops to 0 next cycle. A read of 01 returns 1. A read of 00 returns 64'hDEAD_BEEF_0000_0001 one cycle later, and net_ri=1 the following cycle.
- Input backpressure: in_full=1, net_si held with 64'h2 for 5 cycles -> in_buf keeps its original value. After a read of 00, 64'h2 is captured on the next edge.
- Output path: write 64'h1234 to addr 10 with net_ro=0 -> net_so=1, net_do=64'h1234, and addr 11 reads 1. Raise net_ro -> net_so=0 the next cycle.
- Output overflow: out_full=1, write 64'hFFFF to addr 10 while net_ro=1 on the same edge -> the write is dropped, out_full=0 after the edge, and net_do keeps the old value.
- Illegal accesses: write to addr 00/01/11 and read of addr 10 -> no flag or buffer change; read of 10 returns 0.

Source files
------------

// File: rtl/nic_interface.sv
// NIC responder: memory-mapped register port for the pipeline,
// bridged to the ring router through one-entry channel buffers.
module nic_interface #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  nicEn,
  input  logic                  nicEnWr,
  input  logic [ADDR_WIDTH-1:0] addr_nic,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_out,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [DATA_WIDTH-1:0] net_di,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [DATA_WIDTH-1:0] net_do
);

  localparam logic [ADDR_WIDTH-1:0] A_IBUF = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] A_ISTS = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_OBUF = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_OSTS = ADDR_WIDTH'(3);

  logic [DATA_WIDTH-1:0] in_buf;
  logic                  in_full;
  logic [DATA_WIDTH-1:0] out_buf;
  logic                  out_full;

  logic                  rd;
  logic                  wr;
  logic                  sel_ibuf;
  logic                  sel_ists;
  logic                  sel_obuf;
  logic                  sel_osts;
  logic                  in_take;
  logic                  in_pop;
  logic                  out_push;
  logic                  out_pop;
  logic [DATA_WIDTH-1:0] rd_data;

  // Access qualification and one-hot register select
  always_comb begin
    rd       = nicEn & ~nicEnWr;
    wr       = nicEn & nicEnWr;
    sel_ibuf = (addr_nic == A_IBUF);
    sel_ists = (addr_nic == A_ISTS);
    sel_obuf = (addr_nic == A_OBUF);
    sel_osts = (addr_nic == A_OSTS);
  end

  // Channel events; take/pop on each side are exclusive by the flag
  always_comb begin
    in_take  = net_si & ~in_full;
    in_pop   = rd & sel_ibuf & in_full;
    out_push = wr & sel_obuf & ~out_full;
    out_pop  = out_full & net_ro;
  end

  // Read mux; status values use the pre-edge flags
  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      sel_ibuf: rd_data = in_buf;
      sel_ists: rd_data = {{(DATA_WIDTH-1){1'b0}}, in_full};
      sel_osts: rd_data = {{(DATA_WIDTH-1){1'b0}}, out_full};
      default:  rd_data = '0;
    endcase
  end

  // Input channel buffer filled by the router, drained by reads of 00
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_buf  <= '0;
      in_full <= 1'b0;
    end else begin
      if (in_take)
        in_buf <= net_di;
      unique case (1'b1)
        in_take: in_full <= 1'b1;
        in_pop:  in_full <= 1'b0;
        default: in_full <= in_full;
      endcase
    end
  end

  // Output channel buffer filled by stores to 10, drained by the router
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_buf  <= '0;
      out_full <= 1'b0;
    end else begin
      if (out_push)
        out_buf <= d_in;
      unique case (1'b1)
        out_push: out_full <= 1'b1;
        out_pop:  out_full <= 1'b0;
        default:  out_full <= out_full;
      endcase
    end
  end

  // Registered load data; holds between reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      d_out <= '0;
    else if (rd)
      d_out <= rd_data;
  end

  // Router-facing handshake outputs straight from state
  always_comb begin
    net_ri = ~in_full;
    net_so = out_full;
    net_do = out_buf;
  end

endmodule

// File: tb/tb_nic_interface.sv
// Directed bench for nic_interface: register map, channel
// handshakes, backpressure, dropped writes and async reset.
module tb_nic_interface;

  logic        clk;
  logic        rst;
  logic        nicEn;
  logic        nicEnWr;
  logic [1:0]  addr_nic;
  logic [63:0] d_in;
  logic [63:0] d_out;
  logic        net_si;
  logic        net_ri;
  logic [63:0] net_di;
  logic        net_so;
  logic        net_ro;
  logic [63:0] net_do;

  int tests;
  int fails;

  nic_interface #(.DATA_WIDTH(64), .ADDR_WIDTH(2)) dut (
    .clk(clk), .rst(rst),
    .nicEn(nicEn), .nicEnWr(nicEnWr),
    .addr_nic(addr_nic), .d_in(d_in), .d_out(d_out),
    .net_si(net_si), .net_ri(net_ri), .net_di(net_di),
    .net_so(net_so), .net_ro(net_ro), .net_do(net_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drv_rd(input logic [1:0] a);
    @(negedge clk);
    nicEn = 1'b1; nicEnWr = 1'b0; addr_nic = a;
  endtask

  task automatic drv_wr(input logic [1:0] a, input logic [63:0] d);
    @(negedge clk);
    nicEn = 1'b1; nicEnWr = 1'b1; addr_nic = a; d_in = d;
  endtask

  task automatic drv_idle;
    @(negedge clk);
    nicEn = 1'b0; nicEnWr = 1'b0; addr_nic = 2'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; nicEn = 1'b0; nicEnWr = 1'b0; addr_nic = 2'd0;
    d_in = '0; net_si = 1'b0; net_di = '0; net_ro = 1'b0;
    tick(); tick();
    chk("rst_so", 64'(net_so), 64'd0);
    chk("rst_ri", 64'(net_ri), 64'd1);
    chk("rst_dout", d_out, 64'd0);
    @(negedge clk); rst = 1'b0;

    // input path
    @(negedge clk); net_si = 1'b1; net_di = 64'hDEAD_BEEF_0000_0001;
    tick();
    chk("in_ri_low", 64'(net_ri), 64'd0);
    drv_rd(2'd1); net_si = 1'b0;
    tick();
    chk("in_sts1", d_out, 64'd1);
    drv_rd(2'd0);
    tick();
    chk("in_data", d_out, 64'hDEAD_BEEF_0000_0001);
    chk("in_ri_back", 64'(net_ri), 64'd1);

    // backpressure
    drv_idle(); net_si = 1'b1; net_di = 64'hAAAA;
    tick();
    @(negedge clk); net_di = 64'h2;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_ri", 64'(net_ri), 64'd0);
    end
    drv_rd(2'd0);
    tick();
    chk("bp_first", d_out, 64'hAAAA);
    chk("bp_no_cap", 64'(net_ri), 64'd1);
    drv_idle();
    tick();
    chk("bp_cap_ri", 64'(net_ri), 64'd0);
    drv_rd(2'd0); net_si = 1'b0;
    tick();
    chk("bp_second", d_out, 64'h2);

    // read of empty 00 alongside a capture
    drv_rd(2'd0); net_si = 1'b1; net_di = 64'h3;
    tick();
    chk("stale_dout", d_out, 64'h2);
    chk("stale_cap_ri", 64'(net_ri), 64'd0);
    drv_rd(2'd1); net_si = 1'b0;
    tick();
    chk("stale_sts", d_out, 64'd1);
    drv_rd(2'd0);
    tick();
    chk("stale_data3", d_out, 64'h3);

    // output path
    drv_wr(2'd2, 64'h1234); net_ro = 1'b0;
    tick();
    chk("out_so", 64'(net_so), 64'd1);
    chk("out_do", net_do, 64'h1234);
    chk("out_dout_hold", d_out, 64'h3);
    drv_rd(2'd3);
    tick();
    chk("out_sts1", d_out, 64'd1);

    // overflow write on the handshake edge is dropped
    drv_wr(2'd2, 64'hFFFF); net_ro = 1'b1;
    tick();
    chk("ovf_so", 64'(net_so), 64'd0);
    chk("ovf_do", net_do, 64'h1234);
    drv_rd(2'd3); net_ro = 1'b0;
    tick();
    chk("ovf_sts0", d_out, 64'd0);

    // plain send then router accept
    drv_wr(2'd2, 64'h5555);
    tick();
    chk("snd_so", 64'(net_so), 64'd1);
    drv_idle();
    tick();
    chk("snd_hold", 64'(net_so), 64'd1);
    @(negedge clk); net_ro = 1'b1;
    tick();
    chk("snd_done", 64'(net_so), 64'd0);
    chk("snd_keep", net_do, 64'h5555);
    @(negedge clk); net_ro = 1'b0;

    // illegal accesses with both buffers full
    @(negedge clk); net_si = 1'b1; net_di = 64'h7;
    tick();
    drv_wr(2'd2, 64'h88); net_si = 1'b0;
    tick();
    drv_wr(2'd0, 64'hFF);
    tick();
    drv_wr(2'd1, 64'hFE);
    tick();
    drv_wr(2'd3, 64'hFD);
    tick();
    chk("ill_ri", 64'(net_ri), 64'd0);
    chk("ill_so", 64'(net_so), 64'd1);
    chk("ill_do", net_do, 64'h88);
    chk("ill_dout", d_out, 64'h0);
    drv_rd(2'd1);
    tick();
    chk("ill_dout_sts", d_out, 64'd1);
    drv_rd(2'd2);
    tick();
    chk("ill_rd10", d_out, 64'd0);
    drv_rd(2'd3);
    tick();
    chk("ill_osts", d_out, 64'd1);

    // async reset with both buffers full
    drv_idle();
    #2 rst = 1'b1;
    #1;
    chk("arst_so", 64'(net_so), 64'd0);
    chk("arst_ri", 64'(net_ri), 64'd1);
    chk("arst_dout", d_out, 64'd0);
    chk("arst_do", net_do, 64'd0);
    @(negedge clk); rst = 1'b0;
    drv_rd(2'd1);
    tick();
    chk("post_ists", d_out, 64'd0);
    drv_rd(2'd3);
    tick();
    chk("post_osts", d_out, 64'd0);
    drv_rd(2'd0);
    tick();
    chk("post_ibuf", d_out, 64'd0);
    drv_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
